// File: rtl/mem_access_unit_if.sv
// CPU-side request/response and RAM-wrapper signals for mem_access_unit.
// The slave modport is the sequencer's view; the master modport drives requests and RAM read data.
interface mem_access_unit_if;
  logic        req;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] ram_addr;
  logic [31:0] ram_din;
  logic        ram_we;
  logic [31:0] ram_dout;

  modport slave (
    input  req, req_we, req_size, req_signed, req_addr, req_wdata, ram_dout,
    output stall, done, err, rdata, ram_addr, ram_din, ram_we
  );

  modport master (
    output req, req_we, req_size, req_signed, req_addr, req_wdata, ram_dout,
    input  stall, done, err, rdata, ram_addr, ram_din, ram_we
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store sequencer: turns one CPU request into a timed read or read-merge-write
// against the unaligned RAM wrapper, stalling the CPU until completion.
module mem_access_unit #(
  parameter int READ_CYCLES  = 2,
  parameter int WRITE_CYCLES = 2
) (
  input  logic             clka,
  input  logic             rst_n,
  mem_access_unit_if.slave bus
);

  localparam int MAXC = (READ_CYCLES > WRITE_CYCLES) ? READ_CYCLES : WRITE_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] addr_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] wdata_q;
  logic [31:0] rd_q;
  logic [31:0] rdata_q;
  logic [31:0] ram_addr_q;

  logic        accept;
  logic        rd_last;
  logic [31:0] load_ext;
  logic [31:0] merge;

  assign accept  = (state_q == S_IDLE) && bus.req;
  assign rd_last = (state_q == S_RD) && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          if (bus.req_size == 2'd3) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RD;
            cnt_d   = CW'(READ_CYCLES - 1);
          end
        end
      end
      S_RD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (we_q) begin
          state_d = S_WR;
          cnt_d   = CW'(WRITE_CYCLES - 1);
        end else begin
          state_d = S_DONE;
        end
      end
      S_WR: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else             state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Extension works on the incoming RAM word so rdata is ready on the DONE-entry edge.
  always_comb begin
    load_ext = bus.ram_dout;
    case (size_q)
      2'd0:    load_ext = {{24{signed_q & bus.ram_dout[7]}}, bus.ram_dout[7:0]};
      2'd1:    load_ext = {{16{signed_q & bus.ram_dout[15]}}, bus.ram_dout[15:0]};
      default: load_ext = bus.ram_dout;
    endcase
  end

  always_comb begin
    merge = wdata_q;
    case (size_q)
      2'd0:    merge = {rd_q[31:8], wdata_q[7:0]};
      2'd1:    merge = {rd_q[31:16], wdata_q[15:0]};
      default: merge = wdata_q;
    endcase
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      we_q       <= 1'b0;
      size_q     <= 2'd0;
      signed_q   <= 1'b0;
      wdata_q    <= '0;
      rd_q       <= '0;
      rdata_q    <= '0;
      ram_addr_q <= '0;
    end else begin
      if (accept) begin
        addr_q   <= bus.req_addr;
        we_q     <= bus.req_we;
        size_q   <= bus.req_size;
        signed_q <= bus.req_signed;
        wdata_q  <= bus.req_wdata;
        if (bus.req_size == 2'd3) rdata_q    <= '0;
        else                      ram_addr_q <= bus.req_addr;
      end
      if (rd_last) begin
        rd_q <= bus.ram_dout;
        if (!we_q) rdata_q <= load_ext;
      end
    end
  end

  assign bus.stall    = (state_q == S_RD) || (state_q == S_WR) || accept;
  assign bus.done     = (state_q == S_DONE);
  assign bus.err      = (state_q == S_DONE) && (size_q == 2'd3);
  assign bus.rdata    = rdata_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_we   = (state_q == S_WR);
  assign bus.ram_din  = (state_q == S_WR) ? merge : 32'd0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed, table-driven bench for mem_access_unit with hand-written back-to-back and reset sequences.
module tb_mem_access_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mem_access_unit_if bus ();

  mem_access_unit #(.READ_CYCLES(2), .WRITE_CYCLES(2)) dut (
    .clka  (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] dout;
    logic [31:0] exp_rdata;
    logic [31:0] exp_din;
    logic        exp_err;
    int          exp_stall;
    int          exp_we;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int stalls = 0;
    int wes = 0;
    bit got_done = 0;
    bit addr_bad = 0;
    bit din_bad = 0;
    logic [31:0] r = '0;
    logic e = 1'b0;
    @(posedge clk); #1;
    bus.req        = 1'b1;
    bus.req_we     = v.we;
    bus.req_size   = v.size;
    bus.req_signed = v.sgn;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    bus.ram_dout   = v.dout;
    for (int cyc = 0; cyc < 40 && !got_done; cyc++) begin
      @(negedge clk);
      if (bus.stall) stalls++;
      if (bus.ram_we) begin
        wes++;
        if (bus.ram_din !== v.exp_din) din_bad = 1;
      end
      if (bus.stall && cyc > 0 && bus.ram_addr !== v.addr) addr_bad = 1;
      if (bus.done) begin
        got_done = 1;
        r = bus.rdata;
        e = bus.err;
      end
    end
    bus.req = 1'b0;
    check($sformatf("v%0d_done_seen", idx), 32'(got_done), 32'd1);
    check($sformatf("v%0d_rdata", idx), r, v.exp_rdata);
    check($sformatf("v%0d_err", idx), 32'(e), 32'(v.exp_err));
    check($sformatf("v%0d_stall_cycles", idx), 32'(stalls), 32'(v.exp_stall));
    check($sformatf("v%0d_we_cycles", idx), 32'(wes), 32'(v.exp_we));
    check($sformatf("v%0d_ram_addr", idx), 32'(addr_bad), 32'd0);
    check($sformatf("v%0d_ram_din", idx), 32'(din_bad), 32'd0);
    @(negedge clk);
    check($sformatf("v%0d_done_width", idx), 32'(bus.done), 32'd0);
    $display("vec %0d we=%0d size=%0d sgn=%0d addr=%h rdata=%h err=%0d stalls=%0d we_cycles=%0d",
             idx, v.we, v.size, v.sgn, v.addr, r, e, stalls, wes);
  endtask

  initial begin
    int done_idx[2];
    int nd;
    bit seen_we;
    checks = 0;
    errors = 0;

    //            we    size  sgn   addr          wdata         dout          exp_rdata     exp_din       err   st we
    vecs[0]  = '{1'b0, 2'd2, 1'b0, 32'h00000010, 32'h0,        32'h8899AABB, 32'h8899AABB, 32'h0,        1'b0, 3, 0};
    vecs[1]  = '{1'b1, 2'd1, 1'b0, 32'h00000006, 32'h00001234, 32'hDEADBEEF, 32'h8899AABB, 32'hDEAD1234, 1'b0, 5, 2};
    vecs[2]  = '{1'b0, 2'd0, 1'b1, 32'h00000021, 32'h0,        32'h123456F0, 32'hFFFFFFF0, 32'h0,        1'b0, 3, 0};
    vecs[3]  = '{1'b0, 2'd0, 1'b0, 32'h00000021, 32'h0,        32'h123456F0, 32'h000000F0, 32'h0,        1'b0, 3, 0};
    vecs[4]  = '{1'b0, 2'd1, 1'b1, 32'h00000032, 32'h0,        32'h00008001, 32'hFFFF8001, 32'h0,        1'b0, 3, 0};
    vecs[5]  = '{1'b0, 2'd1, 1'b0, 32'h00000033, 32'h0,        32'h00008001, 32'h00008001, 32'h0,        1'b0, 3, 0};
    vecs[6]  = '{1'b1, 2'd0, 1'b0, 32'h00000103, 32'hFFFFFF55, 32'hDEADBEEF, 32'h00008001, 32'hDEADBE55, 1'b0, 5, 2};
    vecs[7]  = '{1'b1, 2'd2, 1'b0, 32'hFFFFFFFE, 32'hCAFEF00D, 32'h11111111, 32'h00008001, 32'hCAFEF00D, 1'b0, 5, 2};
    vecs[8]  = '{1'b0, 2'd3, 1'b1, 32'h00000044, 32'h0,        32'h77777777, 32'h00000000, 32'h0,        1'b1, 1, 0};
    vecs[9]  = '{1'b0, 2'd2, 1'b1, 32'h00000007, 32'h0,        32'h01234567, 32'h01234567, 32'h0,        1'b0, 3, 0};
    vecs[10] = '{1'b1, 2'd3, 1'b0, 32'h00000088, 32'hFFFFFFFF, 32'h0,        32'h00000000, 32'h0,        1'b1, 1, 0};

    rst_n          = 1'b0;
    bus.req        = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.ram_dout   = '0;
    repeat (2) @(negedge clk);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_err", 32'(bus.err), 32'h0);
    check("rst_ram_we", 32'(bus.ram_we), 32'h0);
    check("rst_ram_addr", bus.ram_addr, 32'h0);
    check("rst_ram_din", bus.ram_din, 32'h0);
    check("rst_stall", 32'(bus.stall), 32'h0);
    $display("reset: rdata=%h done=%0d ram_we=%0d ram_addr=%h", bus.rdata, bus.done, bus.ram_we, bus.ram_addr);
    @(posedge clk); #1 rst_n = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Back-to-back loads with req held; address changes during the first RD.
    @(posedge clk); #1;
    bus.req = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_signed = 1'b0;
    bus.req_addr = 32'h00000040; bus.ram_dout = 32'h000000AA;
    nd = 0;
    done_idx[0] = -1;
    done_idx[1] = -1;
    for (int cyc = 0; cyc < 20 && nd < 2; cyc++) begin
      @(negedge clk);
      if (cyc == 2) check("b2b_ram_addr_held", bus.ram_addr, 32'h00000040);
      if (cyc == 1) bus.req_addr = 32'h00000099;
      if (bus.done) begin
        done_idx[nd] = cyc;
        nd++;
      end
    end
    bus.req = 1'b0;
    check("b2b_done_count", 32'(nd), 32'd2);
    check("b2b_done_gap", 32'(done_idx[1] - done_idx[0]), 32'd4);
    check("b2b_rdata", bus.rdata, 32'h000000AA);
    $display("b2b: done at %0d and %0d rdata=%h", done_idx[0], done_idx[1], bus.rdata);

    // Reset while the store is writing.
    @(posedge clk); #1;
    bus.req = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd0; bus.req_signed = 1'b0;
    bus.req_addr = 32'h00000050; bus.req_wdata = 32'h000000AB; bus.ram_dout = 32'hDEADBEEF;
    seen_we = 0;
    for (int cyc = 0; cyc < 20 && !seen_we; cyc++) begin
      @(negedge clk);
      if (bus.ram_we) seen_we = 1;
    end
    check("rstwr_we_seen", 32'(seen_we), 32'd1);
    rst_n = 1'b0;
    bus.req = 1'b0;
    #1;
    check("rstwr_ram_we", 32'(bus.ram_we), 32'h0);
    check("rstwr_done", 32'(bus.done), 32'h0);
    check("rstwr_stall", 32'(bus.stall), 32'h0);
    check("rstwr_ram_addr", bus.ram_addr, 32'h0);
    check("rstwr_rdata", bus.rdata, 32'h0);
    $display("reset mid-store: ram_we=%0d done=%0d rdata=%h", bus.ram_we, bus.done, bus.rdata);
    @(posedge clk); #1 rst_n = 1'b1;
    run_vec(11, '{1'b0, 2'd2, 1'b0, 32'h00000060, 32'h0, 32'h5A5AA5A5, 32'h5A5AA5A5, 32'h0, 1'b0, 3, 0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
